// File: rtl/sysid_ext_pkg.sv
// ---------------------------------------------------------------------------
// sysid_ext_pkg
// Shared definitions for the system-identification slave: register word
// offsets, CTRL/STATUS bit positions and the byte-lane merge helper used
// by byteenable-qualified writes.
// ---------------------------------------------------------------------------
package sysid_ext_pkg;

    localparam logic [2:0] ADDR_SYS_ID    = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_VERSION   = 3'd2;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
    localparam logic [2:0] ADDR_CTRL      = 3'd6;
    localparam logic [2:0] ADDR_STATUS    = 3'd7;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_CLR   = 1;
    localparam int STATUS_OVF = 0;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// ---------------------------------------------------------------------------
// sysid_uptime_counter
// Free-running uptime counter with enable and synchronous clear.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   en_i     in   count enable
//   clr_i    in   synchronous clear, wins over increment
//   count_o  out  current count value
//   wrap_o   out  high in the cycle whose clock edge takes all-ones to zero
// ---------------------------------------------------------------------------
module sysid_uptime_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A wrap masked by a clear is not reported.
    assign wrap_o  = en_i & ~clr_i & (&count_q);
    assign count_o = count_q;

endmodule

// File: rtl/sysid_ext.sv
// ---------------------------------------------------------------------------
// sysid_ext
// Avalon-MM system-identification and housekeeping slave. Returns fixed
// ID/timestamp/version words, provides a scratch register, and exposes an
// uptime counter whose high half is read coherently through a shadow that
// is captured on every UPTIME_LO read. Reads have a fixed one-cycle latency.
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   address[2:0]   in   word address
//   read           in   read strobe
//   write          in   write strobe
//   writedata[31:0] in  write data
//   byteenable[3:0] in  write byte lanes
//   readdata[31:0] out  registered read data, held between reads
//   readdatavalid  out  one-cycle pulse one cycle after read
// ---------------------------------------------------------------------------
module sysid_ext
    import sysid_ext_pkg::*;
#(
    parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
    parameter int          CNT_W        = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic [31:0]      scratch_q, scratch_d;
    logic             en_q, en_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic [CNT_W-1:0] cnt;
    logic [63:0]      cnt_ext;
    logic             cnt_wrap;
    logic             wr_ctrl;
    logic             wr_status;
    logic             clr_req;
    logic [31:0]      rd_mux;

    assign wr_ctrl   = write && (address == ADDR_CTRL)   && byteenable[0];
    assign wr_status = write && (address == ADDR_STATUS) && byteenable[0];
    // Clear acts on the edge that accepts the CTRL write, so the counter
    // reads zero from the following cycle on.
    assign clr_req   = wr_ctrl && writedata[CTRL_CLR];

    sysid_uptime_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (en_q),
        .clr_i   (clr_req),
        .count_o (cnt),
        .wrap_o  (cnt_wrap)
    );

    // Zero-extend so the high word is well defined for any CNT_W up to 64.
    assign cnt_ext = 64'(cnt);

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_SYS_ID:    rd_mux = ID_VALUE;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_VERSION:   rd_mux = VERSION;
            ADDR_SCRATCH:   rd_mux = scratch_q;
            ADDR_UPTIME_LO: rd_mux = cnt_ext[31:0];
            ADDR_UPTIME_HI: rd_mux = shadow_q;
            ADDR_CTRL:      rd_mux[CTRL_EN]    = en_q;
            ADDR_STATUS:    rd_mux[STATUS_OVF] = ovf_q;
            default:        rd_mux = '0;
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        en_d      = en_q;
        ovf_d     = ovf_q;
        shadow_d  = shadow_q;
        rdata_d   = rdata_q;
        rvalid_d  = read;

        if (write && (address == ADDR_SCRATCH)) begin
            scratch_d = byte_merge(scratch_q, writedata, byteenable);
        end
        if (wr_ctrl) begin
            en_d = writedata[CTRL_EN];
        end
        if (wr_status && writedata[STATUS_OVF]) begin
            ovf_d = 1'b0;
        end
        // A wrap in the same cycle as the W1C leaves the flag set.
        if (cnt_wrap) begin
            ovf_d = 1'b1;
        end

        // Read mux sees pre-write register values.
        if (read) begin
            rdata_d = rd_mux;
            if (address == ADDR_UPTIME_LO) begin
                shadow_d = cnt_ext[63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q <= SCRATCH_INIT;
            en_q      <= 1'b1;
            ovf_q     <= 1'b0;
            shadow_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_ext.sv
module tb_sysid_ext;

    localparam logic [31:0] P_ID    = 32'hDEAD_BEEF;
    localparam logic [31:0] P_TS    = 32'h4C2A_1B00;
    localparam logic [31:0] P_VER   = 32'h0001_0000;
    localparam logic [31:0] P_SINIT = 32'h0000_0000;
    localparam int          P_CW    = 33;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [P_CW-1:0] cnt_preset;

    always #5 clk = ~clk;

    sysid_ext #(
        .ID_VALUE     (P_ID),
        .TIMESTAMP    (P_TS),
        .VERSION      (P_VER),
        .SCRATCH_INIT (P_SINIT),
        .CNT_W        (P_CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        write = 1'b1; address = a; writedata = d; byteenable = be;
        @(negedge clk);
        write = 1'b0; byteenable = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        read = 1'b1; address = a;
        @(posedge clk);
        #1;
        chk("rvalid", {31'b0, readdatavalid}, 32'd1);
        d = readdata;
        @(negedge clk);
        read = 1'b0;
    endtask

    // Deposit a counter value; call just after a falling edge.
    task set_cnt(input logic [P_CW-1:0] v);
        cnt_preset = v;
        force dut.u_cnt.count_q = cnt_preset;
        release dut.u_cnt.count_q;
    endtask

    initial begin
        logic [31:0] d;

        vecs[0]  = '{1'b0, 3'd0, 32'h0,          4'h0,    32'hDEAD_BEEF, "sys_id"};
        vecs[1]  = '{1'b0, 3'd1, 32'h0,          4'h0,    32'h4C2A_1B00, "timestamp"};
        vecs[2]  = '{1'b0, 3'd2, 32'h0,          4'h0,    32'h0001_0000, "version"};
        vecs[3]  = '{1'b0, 3'd3, 32'h0,          4'h0,    32'h0000_0000, "scratch_rst"};
        vecs[4]  = '{1'b0, 3'd7, 32'h0,          4'h0,    32'h0000_0000, "status_rst"};
        vecs[5]  = '{1'b0, 3'd6, 32'h0,          4'h0,    32'h0000_0001, "ctrl_rst"};
        vecs[6]  = '{1'b1, 3'd3, 32'h1234_5678,  4'b0101, 32'h0,         "wr_scratch_0101"};
        vecs[7]  = '{1'b0, 3'd3, 32'h0,          4'h0,    32'h0034_0078, "scratch_0101"};
        vecs[8]  = '{1'b1, 3'd3, 32'hAABB_CCDD,  4'b1010, 32'h0,         "wr_scratch_1010"};
        vecs[9]  = '{1'b0, 3'd3, 32'h0,          4'h0,    32'hAA34_CC78, "scratch_1010"};
        vecs[10] = '{1'b1, 3'd0, 32'hFFFF_FFFF,  4'hF,    32'h0,         "wr_sys_id"};
        vecs[11] = '{1'b0, 3'd0, 32'h0,          4'h0,    32'hDEAD_BEEF, "sys_id_ro"};
        vecs[12] = '{1'b1, 3'd6, 32'h0,          4'b1110, 32'h0,         "wr_ctrl_nobe0"};
        vecs[13] = '{1'b0, 3'd6, 32'h0,          4'h0,    32'h0000_0001, "ctrl_nobe0"};
        vecs[14] = '{1'b1, 3'd3, 32'hFFFF_FFFF,  4'b0000, 32'h0,         "wr_scratch_be0"};
        vecs[15] = '{1'b0, 3'd3, 32'h0,          4'h0,    32'hAA34_CC78, "scratch_be0"};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_rvalid", {31'b0, readdatavalid}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table-driven register checks
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            end else begin
                bus_read(vecs[i].addr, d);
                chk(vecs[i].name, d, vecs[i].exp);
            end
        end

        // Valid is a single-cycle pulse and readdata holds afterwards
        @(negedge clk);
        chk("rvalid_idle", {31'b0, readdatavalid}, 32'd0);
        read = 1'b1; address = 3'd1;
        @(negedge clk);
        chk("rvalid_pulse", {31'b0, readdatavalid}, 32'd1);
        read = 1'b0;
        @(posedge clk); #1;
        chk("rvalid_drop", {31'b0, readdatavalid}, 32'd0);
        chk("rdata_hold", readdata, 32'h4C2A_1B00);

        // Back-to-back reads
        @(negedge clk);
        read = 1'b1; address = 3'd0;
        @(posedge clk); #1;
        chk("b2b_0", readdata, 32'hDEAD_BEEF);
        @(negedge clk);
        address = 3'd2;
        @(posedge clk); #1;
        chk("b2b_2", readdata, 32'h0001_0000);
        chk("b2b_valid", {31'b0, readdatavalid}, 32'd1);
        @(negedge clk);
        read = 1'b0;

        // Read and write of SCRATCH in the same cycle
        @(negedge clk);
        read = 1'b1; write = 1'b1; address = 3'd3; writedata = 32'h1111_1111; byteenable = 4'hF;
        @(posedge clk); #1;
        chk("rw_same_old", readdata, 32'hAA34_CC78);
        @(negedge clk);
        read = 1'b0; write = 1'b0; byteenable = '0;
        bus_read(3'd3, d);
        chk("rw_same_new", d, 32'h1111_1111);

        // Coherent uptime: shadow keeps the latched high word across a wrap
        @(negedge clk);
        set_cnt(33'h1_FFFF_FFFE);
        read = 1'b1; address = 3'd4;
        @(posedge clk); #1;
        chk("uptime_lo", readdata, 32'hFFFF_FFFE);
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        read = 1'b1; address = 3'd5;
        @(posedge clk); #1;
        chk("uptime_hi_shadow", readdata, 32'h0000_0001);
        @(negedge clk);
        read = 1'b0;
        bus_read(3'd7, d);
        chk("ovf_after_wrap", d, 32'd1);
        bus_read(3'd4, d);
        chk("lo_after_wrap_small", {31'b0, (d < 32'd32)}, 32'd1);
        bus_read(3'd5, d);
        chk("hi_after_wrap", d, 32'd0);

        // Sticky overflow, W1C, W1C vs wrap, wrap vs clr
        bus_write(3'd7, 32'd1, 4'b1110);
        bus_read(3'd7, d);
        chk("w1c_nobe0", d, 32'd1);
        bus_write(3'd7, 32'd1, 4'b0001);
        bus_read(3'd7, d);
        chk("w1c_clear", d, 32'd0);
        @(negedge clk);
        set_cnt('1);
        write = 1'b1; address = 3'd7; writedata = 32'd1; byteenable = 4'b0001;
        @(negedge clk);
        write = 1'b0; byteenable = '0;
        bus_read(3'd7, d);
        chk("w1c_vs_wrap", d, 32'd1);
        bus_write(3'd7, 32'd1, 4'b0001);
        @(negedge clk);
        set_cnt('1);
        write = 1'b1; address = 3'd6; writedata = 32'd3; byteenable = 4'b0001;
        @(negedge clk);
        write = 1'b0; byteenable = '0;
        bus_read(3'd7, d);
        chk("clr_masks_wrap", d, 32'd0);

        // Enable off freezes the counter; clr restarts it
        bus_write(3'd6, 32'd0, 4'b0001);
        @(negedge clk);
        set_cnt(33'h0_0000_1234);
        repeat (100) @(posedge clk);
        bus_read(3'd4, d);
        chk("frozen_lo", d, 32'h0000_1234);
        bus_read(3'd5, d);
        chk("frozen_hi", d, 32'h0);
        bus_read(3'd6, d);
        chk("ctrl_off", d, 32'd0);
        bus_write(3'd6, 32'd3, 4'b0001);
        bus_read(3'd4, d);
        chk("clr_lo_0to2", {31'b0, (d <= 32'd2)}, 32'd1);
        bus_read(3'd6, d);
        chk("ctrl_after_clr", d, 32'd1);

        // Reset in the cycle after a read
        @(negedge clk);
        set_cnt(33'h1_0000_0005);
        read = 1'b1; address = 3'd4;
        @(posedge clk); #1;
        chk("pre_rst_lo", readdata, 32'h0000_0005);
        @(negedge clk);
        read = 1'b0;
        set_cnt('1);
        @(negedge clk);
        bus_write(3'd3, 32'h5555_5555, 4'hF);
        @(negedge clk);
        read = 1'b1; address = 3'd3;
        @(posedge clk); #1;
        chk("pre_rst_scratch", readdata, 32'h5555_5555);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", {31'b0, readdatavalid}, 32'd0);
        chk("rst_mid_rdata", readdata, 32'h0);
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd5, d);
        chk("post_rst_shadow", d, 32'h0);
        bus_read(3'd3, d);
        chk("post_rst_scratch", d, P_SINIT);
        bus_read(3'd6, d);
        chk("post_rst_ctrl", d, 32'd1);
        bus_read(3'd7, d);
        chk("post_rst_status", d, 32'd0);
        bus_read(3'd4, d);
        chk("post_rst_lo_small", {31'b0, (d < 32'd32)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sysid_ext.md
Name: sysid_ext

Overview:
Parametrised system-identification and housekeeping slave on the Avalon-MM bus, used by host software to confirm which FPGA image is loaded.
- Read-only: system ID, build timestamp, version word.
- Read-write: scratch register for bus sanity checks.
- Free-running 64-bit uptime counter with a coherent two-word read, enable/clear control, and a sticky wrap flag.
- Registered reads with a fixed latency of one cycle; no waitrequest.

Parameters:
ID_VALUE, 32'h0000_0000, constant returned at SYS_ID.
TIMESTAMP, 32'h0000_0000, build time (Unix seconds) returned at TIMESTAMP.
VERSION, 32'h0001_0000, image version (major[31:16], minor[15:0]).
SCRATCH_INIT, 32'h0000_0000, reset value of SCRATCH.
CNT_W, 64, uptime counter width; legal range 33..64.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word address
read  in  1  read strobe
write  in  1  write strobe
writedata  in  32  write data
byteenable  in  4  byte lanes for writes
readdata  out  32  read data, registered
readdatavalid  out  1  one-cycle pulse, one cycle after read

Behaviour:
- Reset is asynchronous assert, synchronous deassert by the system.
- Reset values:
  - readdata = 0, readdatavalid = 0
  - SCRATCH = SCRATCH_INIT
  - counter = 0, shadow = 0
  - CTRL.en = 1
  - STATUS.ovf = 0
- Register map (word offset):
  - 0 SYS_ID (RO)
  - 1 TIMESTAMP (RO)
  - 2 VERSION (RO)
  - 3 SCRATCH (RW, byteenable honoured)
  - 4 UPTIME_LO (RO)
  - 5 UPTIME_HI (RO, reads shadow)
  - 6 CTRL (bit0 en RW; bit1 clr write-1 self-clearing, reads 0; others 0)
  - 7 STATUS (bit0 ovf, W1C; others 0)
- Writes to RO registers are ignored.
- CTRL and STATUS writes apply only when byteenable[0] = 1.
- Read: read asserted in cycle N -> readdata valid and readdatavalid = 1 in cycle N+1.
  - Back-to-back reads are supported, one per cycle.
  - readdata holds its last value when readdatavalid = 0.
- Coherent uptime read:
  - A read of UPTIME_LO returns counter[31:0] and, in the same cycle, latches counter[CNT_W-1:32] (zero-extended to 32 bits) into shadow.
  - UPTIME_HI returns shadow, never the live counter.
- Counter behaviour:
  - Increments by 1 per clk when en = 1; holds when en = 0.
  - At all-ones it wraps to 0 and sets ovf in the same cycle.
- clr:
  - Zeroes the counter on the cycle after the write.
  - Does not touch shadow or ovf.
  - clr has priority over increment, and a wrap coinciding with clr does not set ovf.
- Simultaneous events:
  - read and write in the same cycle: the write takes effect; readdata returns the pre-write value.
  - ovf set event and W1C in the same cycle: set wins, ovf = 1.
- Reset mid-read: readdatavalid drops to 0 immediately, and the pending read is discarded.

Decomposition:
- Package sysid_ext_pkg:
  - register offset constants (SYS_ID .. STATUS)
  - CTRL bit indices (EN = 0, CLR = 1)
  - STATUS bit index (OVF = 0)
  - a byte-merge function for byteenable writes
- One sub-module, sysid_uptime_counter:
  - inputs clk, reset_n, en, clr
  - outputs count[CNT_W-1:0] and a wrap pulse
- Top level holds the register file, read mux, shadow and status logic.

Test Plan:
- Reset, then read addresses 0/1/2 with ID_VALUE = 32'hDEADBEEF, TIMESTAMP = 32'h4C2A_1B00 -> readdata DEADBEEF, 4C2A1B00, 00010000; each readdatavalid exactly one cycle after its read.
- Write SCRATCH = 32'h1234_5678 with byteenable = 4'b0101 from reset value 0 -> read returns 32'h0034_0078; write to SYS_ID ignored, still reads DEADBEEF.
- Force the counter to 32'hFFFF_FFFF (low word) via a hierarchical deposit, read UPTIME_LO then UPTIME_HI while it keeps counting -> HI = 0x0000_0001 matching the latched value, not the live value.
- CNT_W = 33, counter preset to all-ones, en = 1 -> wraps to 0, STATUS reads 1; write STATUS = 1 -> reads 0; W1C on the same cycle as a wrap -> reads 1.
- Write CTRL = 0 -> counter frozen across 100 cycles; write CTRL = 3 -> counter reads 0..2 on the next UPTIME_LO read, CTRL reads back 1.
- Assert reset_n = 0 in the cycle after a read -> readdatavalid = 0 and all registers at reset values; SCRATCH = SCRATCH_INIT.
